// File: rtl/mdu_if.sv
// Request and writeback handshake bundle for the RV32M multiply/divide unit.
// The requester/consumer side uses the master modport; the unit uses slave.
interface mdu_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_rd;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  modport master (
    output req_valid, req_op, req_a, req_b, req_rd, wb_ready,
    input  req_ready, wb_valid, wb_rd, wb_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_rd, wb_ready,
    output req_ready, wb_valid, wb_rd, wb_data
  );
endinterface

// File: rtl/mdu.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply or restoring
// divide on operand magnitudes, sign fix-up on the final step, registered writeback.
module mdu (
  input  logic  aclk,
  input  logic  reset,
  mdu_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return (~x) + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] x);
    return (~x) + 64'd1;
  endfunction

  state_t      state_r;
  state_t      state_s;
  logic [4:0]  cnt_r;
  logic [2:0]  op_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic [31:0] opnd_r;
  logic        neg_r;
  logic        wb_valid_r;
  logic [4:0]  wb_rd_r;
  logic [31:0] wb_data_r;

  logic        accept_s;
  logic        signed_a_s;
  logic        signed_b_s;
  logic        sign_a_s;
  logic        sign_b_s;
  logic [31:0] mag_a_s;
  logic [31:0] mag_b_s;
  logic        neg_s;
  logic        special_s;
  logic [31:0] special_data_s;

  logic [32:0] sum_s;
  logic [32:0] rem_shift_s;
  logic        ge_s;
  logic [31:0] hi_nxt_s;
  logic [31:0] lo_nxt_s;
  logic [63:0] prod_s;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [31:0] result_s;
  logic        last_s;

  assign accept_s      = bus.req_valid && (state_r == S_IDLE);
  assign last_s        = (cnt_r == 5'd31);
  assign bus.req_ready = (state_r == S_IDLE);
  assign bus.wb_valid  = wb_valid_r;
  assign bus.wb_rd     = wb_rd_r;
  assign bus.wb_data   = wb_data_r;

  // Operand decode: signedness, magnitudes, result sign and divide special cases.
  always_comb begin
    signed_a_s     = 1'b0;
    signed_b_s     = 1'b0;
    special_s      = 1'b0;
    special_data_s = 32'd0;
    case (bus.req_op)
      OP_MULH:   begin signed_a_s = 1'b1; signed_b_s = 1'b1; end
      OP_MULHSU: begin signed_a_s = 1'b1; signed_b_s = 1'b0; end
      OP_DIV:    begin signed_a_s = 1'b1; signed_b_s = 1'b1; end
      OP_REM:    begin signed_a_s = 1'b1; signed_b_s = 1'b1; end
      default:   begin signed_a_s = 1'b0; signed_b_s = 1'b0; end
    endcase
    sign_a_s = signed_a_s & bus.req_a[31];
    sign_b_s = signed_b_s & bus.req_b[31];
    mag_a_s  = sign_a_s ? neg32(bus.req_a) : bus.req_a;
    mag_b_s  = sign_b_s ? neg32(bus.req_b) : bus.req_b;
    // Remainder takes the dividend's sign; everything else the product of signs.
    if (bus.req_op == OP_REM) begin
      neg_s = sign_a_s;
    end else begin
      neg_s = sign_a_s ^ sign_b_s;
    end
    if (bus.req_op[2] && (bus.req_b == 32'd0)) begin
      special_s      = 1'b1;
      special_data_s = bus.req_op[1] ? bus.req_a : 32'hFFFF_FFFF;
    end else if (!bus.req_op[0] && bus.req_op[2] &&
                 (bus.req_a == 32'h8000_0000) && (bus.req_b == 32'hFFFF_FFFF)) begin
      special_s      = 1'b1;
      special_data_s = bus.req_op[1] ? 32'd0 : 32'h8000_0000;
    end else begin
      special_s      = 1'b0;
      special_data_s = 32'd0;
    end
  end

  // One iteration step: hi/lo hold product halves, or remainder/quotient-dividend.
  always_comb begin
    sum_s       = 33'd0;
    rem_shift_s = {hi_r, lo_r[31]};
    ge_s        = 1'b0;
    hi_nxt_s    = hi_r;
    lo_nxt_s    = lo_r;
    if (op_r[2]) begin
      ge_s = (rem_shift_s >= {1'b0, opnd_r});
      if (ge_s) begin
        hi_nxt_s = rem_shift_s[31:0] - opnd_r;
        lo_nxt_s = {lo_r[30:0], 1'b1};
      end else begin
        hi_nxt_s = rem_shift_s[31:0];
        lo_nxt_s = {lo_r[30:0], 1'b0};
      end
    end else begin
      sum_s    = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : 33'd0);
      hi_nxt_s = sum_s[32:1];
      lo_nxt_s = {sum_s[0], lo_r[31:1]};
    end
  end

  // Final result from the last step's values, with sign fix-up applied.
  always_comb begin
    prod_s = neg_r ? neg64({hi_nxt_s, lo_nxt_s}) : {hi_nxt_s, lo_nxt_s};
    quo_s  = neg_r ? neg32(lo_nxt_s) : lo_nxt_s;
    rem_s  = neg_r ? neg32(hi_nxt_s) : hi_nxt_s;
    case (op_r)
      OP_MUL:    result_s = prod_s[31:0];
      OP_MULH:   result_s = prod_s[63:32];
      OP_MULHSU: result_s = prod_s[63:32];
      OP_MULHU:  result_s = prod_s[63:32];
      OP_DIV:    result_s = quo_s;
      OP_DIVU:   result_s = quo_s;
      OP_REM:    result_s = rem_s;
      OP_REMU:   result_s = rem_s;
      default:   result_s = 32'd0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_s = special_s ? S_DONE : S_BUSY;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_BUSY: begin
        if (last_s) begin
          state_s = S_DONE;
        end else begin
          state_s = S_BUSY;
        end
      end
      S_DONE: begin
        if (bus.wb_ready) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_DONE;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture, iteration registers and writeback registers.
  always_ff @(posedge aclk) begin
    if (reset) begin
      cnt_r      <= 5'd0;
      op_r       <= 3'd0;
      hi_r       <= 32'd0;
      lo_r       <= 32'd0;
      opnd_r     <= 32'd0;
      neg_r      <= 1'b0;
      wb_valid_r <= 1'b0;
      wb_rd_r    <= 5'd0;
      wb_data_r  <= 32'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            op_r    <= bus.req_op;
            wb_rd_r <= bus.req_rd;
            neg_r   <= neg_s;
            cnt_r   <= 5'd0;
            hi_r    <= 32'd0;
            if (bus.req_op[2]) begin
              lo_r   <= mag_a_s;
              opnd_r <= mag_b_s;
            end else begin
              lo_r   <= mag_b_s;
              opnd_r <= mag_a_s;
            end
            if (special_s) begin
              wb_data_r <= special_data_s;
            end
          end
        end
        S_BUSY: begin
          cnt_r <= cnt_r + 5'd1;
          hi_r  <= hi_nxt_s;
          lo_r  <= lo_nxt_s;
          if (last_s) begin
            wb_data_r <= result_s;
          end
        end
        S_DONE: begin
          cnt_r <= 5'd0;
        end
        default: begin
          cnt_r <= 5'd0;
        end
      endcase
      wb_valid_r <= (state_s == S_DONE);
    end
  end

endmodule

// File: doc/mdu.md
# mdu

Iterative RV32M multiply/divide unit feeding the register-file write port. Accepts one M-extension operation with valid/ready, computes it over 32 cycles (one cycle for divide special cases), and holds the result on a valid/ready writeback interface. The interface carries destination index, data and valid. The writeback stage forwards these as rd, rd_data and write_en.

## Interface
- None; datapath fixed at 32 bits, operation encoding fixed to RV32M funct3.

- aclk  input  1  clock; one clock; all state updates on rising edge
- reset  input  1  reset is synchronous and active-high
- req_valid  input  1  request present
- req_ready  output  1  unit can accept; high only in IDLE
- req_op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- req_a  input  32  rs1 operand
- req_b  input  32  rs2 operand
- req_rd  input  5  destination register index
- wb_valid  output  1  result present
- wb_ready  input  1  writeback consumer accepts
- wb_rd  output  5  destination index of result
- wb_data  output  32  result

## Operation
- States:
  - IDLE: req_ready=1.
  - BUSY: 32 iteration cycles.
  - DONE: wb_valid=1.
- Accept: req_valid && req_ready at a rising edge.
  - Captures req_op, req_a, req_b and req_rd.
  - Inputs may change afterwards with no effect.
- IDLE to BUSY on accept for all MUL* ops and for non-special divides.
- IDLE to DONE directly on accept for divide special cases.
- BUSY: 5-bit iteration counter runs 0..31. On count 31 the next state is DONE.
- Multiply: shift-add over 64-bit product.
  - MUL returns product[31:0], identical for signed/unsigned.
  - MULH returns [63:32] of signed×signed.
  - MULHSU returns [63:32] of signed a × unsigned b.
  - MULHU returns [63:32] of unsigned×unsigned.
- Divide: restoring, on magnitudes, with sign fix-up after iteration.
  - DIV/DIVU quotient rounds toward zero.
  - REM/REMU remainder sign follows dividend.
- Special cases (no iteration):
  - b==0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return req_a.
  - DIV with a=0x80000000, b=0xFFFFFFFF returns 0x80000000; REM with the same operands returns 0.
- DONE: wb_valid=1; wb_rd and wb_data held stable until wb_valid && wb_ready; then next state IDLE.
- req_rd==0: computed and presented normally; the register file discards x0 writes.
- No request accepted in BUSY or DONE, including the handshake cycle of a result.
- Reset in any state:
  - Next state IDLE, wb_valid=0.
  - In-flight operation discarded; no writeback ever appears for it.

## Timing
- Reset values: state IDLE, req_ready=1, wb_valid=0, wb_rd=0, wb_data=0, counter=0.
- req_ready is combinational from state only; never depends on req_valid.
- wb_valid and wb_data come from registers; no combinational path from req_* to wb_*.
- Normal op accepted at edge N: BUSY during cycles N+1..N+32; wb_valid high from cycle N+33.
- Special-case divide accepted at edge N: wb_valid high in cycle N+1.
- Result handshake at edge M: wb_valid=0 and req_ready=1 in cycle M+1; earliest next accept at edge M+1.
- Throughput with wb_ready tied high:
  - One normal op every 34 cycles.
  - One special-case divide every 2 cycles.
- wb_ready low stalls indefinitely in DONE with outputs unchanged.

## Test plan
- Reset then MUL, a=7, b=0xFFFFFFFD, rd=5, accepted at edge N:
  - req_ready=0 during N+1..N+33.
  - wb_valid first high in N+33 with wb_rd=5, wb_data=0xFFFFFFEB.
- High-half multiplies:
  - MULH 0x80000000×0x80000000 gives 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF gives 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF gives 0xFFFFFFFF.
  - MUL 0x10000×0x10000 gives 0x00000000.
- Divides, each with wb_valid at N+33:
  - DIV −7/2 (0xFFFFFFF9, 2) gives 0xFFFFFFFD.
  - REM −7/2 gives 0xFFFFFFFF.
  - DIVU 100/7 gives 14.
  - REMU 100/7 gives 2.
- Special cases, each with wb_valid in N+1:
  - DIV 5/0 gives 0xFFFFFFFF.
  - REMU 5/0 gives 5.
  - DIV 0x80000000/0xFFFFFFFF gives 0x80000000.
  - REM with the same operands gives 0.
- Backpressure: wb_ready low for 10 cycles after wb_valid rises.
  - wb_valid, wb_rd and wb_data stay constant; req_ready=0 and req_valid is ignored.
  - After the handshake, req_ready=1 next cycle.
- Reset asserted for one cycle in the 10th BUSY cycle:
  - Next cycle IDLE, wb_valid=0.
  - No writeback appears in the following 40 cycles.
  - A fresh DIVU 100/7 then returns 14.
